cp0_unit: RTL

Coprocessor-0 for the pipelined MIPS core: holds SR, Cause, EPC and PRId, arbitrates hardware interrupts against internal exceptions reported by the M stage, and drives `intreq`/`epc` back into the CPU. It sits directly downstream of the CPU top level, consuming its `ismtc0`, `cp0dst`, `wdbus`, `pc8_m`, `bd`, `exccode` and `exlclr` outputs. It produces the CPU's `cp0_rd`, `intreq` and `cp0_epc` inputs.

---
 rtl/cp0_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 holding SR, Cause, EPC and PRId. It arbitrates
// level-sensitive device interrupts against M-stage internal exceptions and
// drives the exception request and return address back into the CPU.
// Optional build macro: CP0_EPC_BYPASS_EN forwards an mtc0 EPC write straight
// onto the epc output in the same cycle.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2016_0601
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        we,
  input  logic [4:0]  cp0dst,
  input  logic [31:0] wd,
  input  logic [31:0] pc8_m,
  input  logic        bd,
  input  logic [4:0]  exccode,
  input  logic        exlclr,
  input  logic [5:0]  hwint,
  output logic [31:0] cp0_rd,
  output logic        intreq,
  output logic [31:0] epc
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Architectural state; only the implemented fields are stored.
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;

  logic        irq;
  logic        exc;
  logic        sr_write;
  logic        epc_write;
  logic [31:0] epc_entry;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Masked interrupts and internal exceptions are both blocked while EXL is
  // set, so no nested exception can be requested.
  assign irq    = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
  assign exc    = (exccode != 5'd0) & ~sr_exl;
  assign intreq = irq | exc;

  assign sr_write  = we && (cp0dst == REG_SR);
  assign epc_write = we && (cp0dst == REG_EPC);

  // A delay-slot instruction must restart at its branch, one word earlier.
  assign epc_entry = bd ? (pc8_m - 32'd12) : (pc8_m - 32'd8);

  assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

  // Register update: reset beats exception entry, which beats eret, which
  // beats an mtc0 write; IP simply follows hwint one cycle late.
  always_ff @(posedge clk) begin
    if (!clr) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      cause_ip <= hwint;
      if (intreq) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd;
        cause_exc <= exc ? exccode : 5'd0;
        epc_q     <= epc_entry & 32'hFFFF_FFFC;
      end else begin
        if (sr_write) begin
          sr_im  <= wd[15:10];
          sr_exl <= wd[1];
          sr_ie  <= wd[0];
        end
        if (epc_write) begin
          epc_q <= wd & 32'hFFFF_FFFC;
        end
        if (exlclr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  // Combinational read port; unmapped indices read as zero.
  always_comb begin
    cp0_rd = 32'd0;
    case (cp0dst)
      REG_SR:    cp0_rd = sr_word;
      REG_CAUSE: cp0_rd = cause_word;
      REG_EPC:   cp0_rd = epc_q;
      REG_PRID:  cp0_rd = PRID;
      default:   cp0_rd = 32'd0;
    endcase
  end

`ifdef CP0_EPC_BYPASS_EN
  // Forward a same-cycle mtc0 EPC write so an immediately following eret
  // sees the new return address.
  always_comb begin
    epc = epc_q;
    if (epc_write) begin
      epc = wd & 32'hFFFF_FFFC;
    end
  end
`else
  // Registered EPC only; the CPU forwards any in-flight mtc0 EPC itself.
  always_comb begin
    epc = epc_q;
  end
`endif

endmodule
